// File: rtl/arb_pkg.sv
// Shared types for the register write-port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_REQ = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate so the search starts after
// last_grant, take the lowest set bit, then rotate the offset back.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    // One extra bit so base + offset never overflows before the wrap.
    localparam int CW = IDX_W + 1;

    logic [CW-1:0]    base;
    logic [CW-1:0]    offset;
    logic [CW-1:0]    sum;
    logic [N_REQ-1:0] rotated;

    always_comb begin
        base = '0;
        if ({1'b0, last_grant} != CW'(N_REQ - 1)) begin
            base = {1'b0, last_grant} + CW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [CW-1:0] raw;
            logic [CW-1:0] src;
            assign raw = base + CW'(gi);
            assign src = (raw >= CW'(N_REQ)) ? raw - CW'(N_REQ) : raw;
            assign rotated[gi] = req[src[IDX_W-1:0]];
        end
    endgenerate

    always_comb begin
        any    = 1'b0;
        offset = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                any    = 1'b1;
                offset = CW'(j);
            end
        end
    end

    always_comb begin
        sum    = base + offset;
        winner = (sum >= CW'(N_REQ)) ? IDX_W'(sum - CW'(N_REQ)) : IDX_W'(sum);
    end

endmodule

// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter sharing one register write port among N_REQ groups;
// each grant runs IDLE -> BUSY (until reg_ready) -> DONE (req_ready pulse).
module reg_port_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   reg_valid,
    output logic [WIDTH-1:0]       reg_in,
    input  logic                   reg_ready,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_idx
);

    arb_state_t       state_reg;
    logic [IDX_W-1:0] last_grant_reg;
    logic [IDX_W-1:0] grant_idx_reg;
    logic [N_REQ-1:0] req_ready_reg;
    logic             reg_valid_reg;
    logic             busy_reg;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .any        (pick_any),
        .winner     (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= IDX_W'(N_REQ - 1);
            grant_idx_reg  <= '0;
            req_ready_reg  <= '0;
            reg_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= '0;
                    if (pick_any) begin
                        grant_idx_reg <= pick_idx;
                        reg_valid_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= BUSY;
                    end
                end
                BUSY: begin
                    // The grant is committed: req_valid is not re-examined here.
                    if (reg_ready) begin
                        reg_valid_reg <= 1'b0;
                        req_ready_reg <= N_REQ'(1) << grant_idx_reg;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    req_ready_reg  <= '0;
                    busy_reg       <= 1'b0;
                    last_grant_reg <= grant_idx_reg;
                    state_reg      <= IDLE;
                end
                default: begin
                    req_ready_reg <= '0;
                    reg_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    // Write data follows the granted requester live while BUSY.
    always_comb begin
        reg_in = '0;
        if (state_reg == BUSY) begin
            reg_in = req_data[grant_idx_reg * WIDTH +: WIDTH];
        end
    end

    assign req_ready = req_ready_reg;
    assign reg_valid = reg_valid_reg;
    assign busy      = busy_reg;
    assign grant_idx = grant_idx_reg;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter with N_REQ=3, WIDTH=32.
module tb_reg_port_arbiter;

    localparam int N = 3;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          reg_valid;
    logic [W-1:0]  reg_in;
    logic          reg_ready;
    logic          busy;
    logic [1:0]    grant_idx;

    logic          tie_rdy;
    logic          man_rdy;
    logic [W-1:0]  d0, d1, d2;

    int checks   = 0;
    int failures = 0;

    assign req_data  = {d2, d1, d0};
    assign reg_ready = tie_rdy ? reg_valid : man_rdy;

    reg_port_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .reg_valid (reg_valid),
        .reg_in    (reg_in),
        .reg_ready (reg_ready),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] exp_data(input int idx);
        return (idx == 0) ? d0 : (idx == 1) ? d1 : d2;
    endfunction

    task automatic do_reset;
        reset     = 1'b1;
        req_valid = '0;
        man_rdy   = 1'b0;
        tie_rdy   = 1'b0;
        tick;
        check("rst_reg_valid", 64'(reg_valid), 64'd0);
        check("rst_reg_in",    64'(reg_in),    64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        tick;
        reset = 1'b0;
    endtask

    // Called in an IDLE cycle with the request already driven; returns in
    // the IDLE cycle after the DONE pulse. reg_ready is raised in BUSY cycle k.
    task automatic serve(input int idx, input int k, input bit reassert, input bit withdraw);
        tick;
        for (int i = 0; i <= k; i++) begin
            man_rdy = (i == k);
            check("busy_reg_valid", 64'(reg_valid), 64'd1);
            check("busy_reg_in",    64'(reg_in),    64'(exp_data(idx)));
            check("busy_grant_idx", 64'(grant_idx), 64'(idx));
            check("busy_flag",      64'(busy),      64'd1);
            check("busy_no_ready",  64'(req_ready), 64'd0);
            if (withdraw && i == 0) req_valid[idx] = 1'b0;
            tick;
        end
        man_rdy = 1'b0;
        check("done_req_ready", 64'(req_ready), 64'd1 << idx);
        check("done_reg_valid", 64'(reg_valid), 64'd0);
        check("done_reg_in",    64'(reg_in),    64'd0);
        check("done_busy",      64'(busy),      64'd1);
        check("done_grant_idx", 64'(grant_idx), 64'(idx));
        req_valid[idx] = 1'b0;
        tick;
        check("idle_req_ready", 64'(req_ready), 64'd0);
        check("idle_busy",      64'(busy),      64'd0);
        check("idle_reg_valid", 64'(reg_valid), 64'd0);
        if (reassert) req_valid[idx] = 1'b1;
        $display("grant idx=%0d wait=%0d data=%h", idx, k, exp_data(idx));
    endtask

    initial begin
        d0 = 32'h1111_0000;
        d1 = 32'h0000_00A5;
        d2 = 32'hDEAD_BEEF;
        reset = 1'b1; req_valid = '0; man_rdy = 1'b0; tie_rdy = 1'b0;

        // Single request with reg_ready tied to reg_valid.
        do_reset;
        tie_rdy   = 1'b1;
        req_valid = 3'b010;
        serve(1, 0, 1'b0, 1'b0);
        tie_rdy   = 1'b0;

        // Simultaneous requests after reset: order 0,1,2.
        do_reset;
        req_valid = 3'b111;
        serve(0, 0, 1'b0, 1'b0);
        serve(1, 0, 1'b0, 1'b0);
        serve(2, 0, 1'b0, 1'b0);

        // Continuous load on 0 and 2 alternates.
        req_valid = 3'b101;
        for (int g = 0; g < 6; g++) serve((g % 2 == 0) ? 0 : 2, 0, 1'b1, 1'b0);
        req_valid = '0;

        // Register acknowledges 4 cycles after the strobe rises.
        req_valid = 3'b010;
        serve(1, 4, 1'b0, 1'b0);

        // Reset while requester 2 is in BUSY.
        req_valid = 3'b100;
        tick;
        check("mid_grant_idx", 64'(grant_idx), 64'd2);
        check("mid_reg_valid", 64'(reg_valid), 64'd1);
        reset     = 1'b1;
        req_valid = '0;
        tick;
        check("mid_rst_reg_valid", 64'(reg_valid), 64'd0);
        check("mid_rst_busy",      64'(busy),      64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        check("mid_rst_grant_idx", 64'(grant_idx), 64'd0);
        reset = 1'b0;
        tick;
        check("post_rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = 3'b110;
        serve(1, 0, 1'b0, 1'b0);
        serve(2, 0, 1'b0, 1'b0);

        // Requester 0 withdraws during BUSY; the write still completes.
        req_valid = 3'b001;
        serve(0, 2, 1'b0, 1'b1);
        tick;
        check("withdraw_no_regrant", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_port_arbiter.md
# reg_port_arbiter

Round-robin arbiter that shares one `register` instance's write port among `N_REQ` enable-group FSMs using the valid/ready group handshake. It sits between several group FSMs and a single `register`, in place of a dedicated register per group. It serialises their writes, muxes write data, and returns a one-cycle `ready` to the winning group. Every requester is guaranteed service within `N_REQ` grants.

## Interface
Parameters:
- `N_REQ`, default 3: number of requesting groups; legal range 2..16.
- `WIDTH`, default 32: data width of the shared register.
- `IDX_W`, default `$clog2(N_REQ)`: grant index width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  `N_REQ`  per-group write request; held high until that group's `req_ready` pulse.
- `req_data`  in  `N_REQ*WIDTH`  packed write data; group i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  `N_REQ`  one-cycle completion pulse to the granted group.
- `reg_valid`  out  1  write strobe to the shared register.
- `reg_in`  out  `WIDTH`  data to the shared register.
- `reg_ready`  in  1  register write complete.
- `busy`  out  1  high in BUSY and DONE.
- `grant_idx`  out  `IDX_W`  index of the current or most recent grant.

## Operation
- State machine: IDLE, BUSY, DONE.
- **IDLE.** All outputs are inactive.
  - If any `req_valid` bit is high, pick the winner by round-robin, starting at `(last_grant+1) mod N_REQ`.
  - Latch the winner into `grant_idx`, then go to BUSY.
  - If no bit is high, stay in IDLE.
- **BUSY.**
  - `reg_valid`=1.
  - `reg_in` = `req_data` slice for `grant_idx`, sampled live each cycle (not latched).
  - When `reg_ready`=1, go to DONE; otherwise stay in BUSY.
- **DONE.**
  - `req_ready[grant_idx]`=1 for exactly one cycle; `reg_valid`=0.
  - Update `last_grant` ← `grant_idx`, then go to IDLE.
- **Committed grant.** The grant is committed once latched. If the winner drops `req_valid` during BUSY, the write is still completed and `req_ready` is still pulsed.
- **Requester rule.** A requester must deassert `req_valid` at the clock edge that ends its `req_ready` cycle. If the bit is still high in the following IDLE cycle, it is treated as a new request.
- **Idle outputs.** Non-granted `req_ready` bits are always 0. `reg_in` = 0 outside BUSY.
- **Reset.** `reset` from any state has these effects:
  - State goes to IDLE.
  - `last_grant` is set to `N_REQ-1`, so requester 0 has first priority after reset.
  - `grant_idx`=0.
  - Any in-flight grant is abandoned and no `req_ready` is issued for it.
- **Reset values.** `reg_valid`=0, `reg_in`=0, `req_ready`=0, `busy`=0, `grant_idx`=0.
- **Out-of-range index.** A `grant_idx` ≥ `N_REQ` is never produced. The picker wraps the search modulo `N_REQ`.

## Timing
- Request sampled in IDLE at cycle t → `reg_valid` high at t+1.
- `reg_ready` first seen high at cycle t+1+k (k ≥ 0) → `req_ready` pulse at t+2+k → IDLE at t+3+k.
- Minimum service time is 3 cycles per grant: IDLE, BUSY, DONE.
- Back-to-back grants under full load have a period of k+3 cycles.
- Worst-case wait for any requester is `N_REQ-1` intervening grants.
- `reg_ready` is ignored outside BUSY.
- New requests that arrive during BUSY or DONE wait for the next IDLE cycle.
- `busy` is registered from state and is valid the cycle after each transition.

## Structure
- **Shared package `arb_pkg`:**
  - `arb_state_t` enum: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - `ARB_MAX_REQ`=16.
- **Sub-module `rr_pick`:** purely combinational picker.
  - Inputs: request vector and `last_grant`.
  - Outputs: `any` flag and winner index.
  - Implemented as a rotate, then priority-encode, then un-rotate.
- **Top level:** state register, `last_grant`/`grant_idx` registers, data mux, output decode.

## Test plan
- **Single request, no wait:** `N_REQ`=3, `WIDTH`=32; raise `req_valid`=3'b010 with data1=32'hA5 while `reg_ready` is tied to `reg_valid`.
  - Required: `reg_valid` high 1 cycle with `reg_in`=32'hA5.
  - Required: `req_ready`=3'b010 two cycles after the request is sampled; `grant_idx`=1.
- **Simultaneous requests after reset:** `req_valid`=3'b111, with each requester dropping its bit after its own ready pulse.
  - Required: grant order 0,1,2; `reg_in` sequence data0, data1, data2.
  - Required: three `req_ready` pulses spaced 3 cycles apart.
- **Fairness under continuous load:** hold 3'b101 continuously, re-asserting each bit one cycle after its pulse, for 6 grants.
  - Required: grant sequence 0,2,0,2,0,2.
- **Delayed register ready:** `reg_ready` arrives 4 cycles after `reg_valid` rises.
  - Required: `reg_valid` and `reg_in` held stable for 5 cycles.
  - Required: `req_ready` one cycle after `reg_ready`, pulse width 1.
- **Reset mid-BUSY:** assert `reset` during BUSY for requester 2.
  - Required: next cycle `reg_valid`=0, `busy`=0, no `req_ready` issued.
  - Required: a following 3'b110 request is granted to 1 first.
- **Withdrawn request:** requester 0 drops `req_valid` during BUSY.
  - Required: the write still completes and `req_ready[0]` still pulses once.
